// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - loader_state_t : loader FSM states
//   - MAGIC_DEFAULT  : default image start byte
//   - image format constants (bytes per word, byte-lane index width,
//     width of the little-endian word count carried in the header)
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         LANE_W         = 2;
    localparam int         COUNT_W        = 16;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_boot_loader_packer.sv
// -----------------------------------------------------------------------------
// boot_word_packer
// Collects payload bytes little-endian into 32-bit words. Byte k of a word
// lands in bits [8k+7:8k]; on the fourth byte the completed word is
// registered and word_valid pulses for exactly one cycle.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   clear          drop any partial word and restart at lane 0
//   byte_valid     a payload byte is presented on byte_data this cycle
//   byte_data      payload byte
//   last_lane      current byte would complete a word (lane index == 3)
//   word_valid     one-cycle strobe, cycle after the completing byte
//   word_data      last completed word, held between strobes
// -----------------------------------------------------------------------------
module boot_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic              word_valid_q, word_valid_d;
    logic [31:0]       word_q, word_d;

    // Lanes 0..2 are buffered; lane 3 is taken straight from byte_data
    // when the word completes, so it never needs its own register.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            logic [7:0] byte_q, byte_d;

            always_comb begin
                byte_d = byte_q;
                if (!clear && byte_valid && (lane_q == LANE_W'(gi))) begin
                    byte_d = byte_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byte_q <= 8'h00;
                end else begin
                    byte_q <= byte_d;
                end
            end
        end
    endgenerate

    assign last_lane = (lane_q == LAST_LANE);

    always_comb begin
        lane_d       = lane_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            lane_d = '0;
        end else if (byte_valid) begin
            // lane index wraps 3 -> 0 naturally
            lane_d = lane_q + LANE_W'(1);
            if (last_lane) begin
                word_d       = {byte_data, g_lane[2].byte_q, g_lane[1].byte_q, g_lane[0].byte_q};
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q       <= '0;
            word_q       <= 32'h0000_0000;
            word_valid_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a byte stream, writes it word-by-word into
// instruction memory and then releases the CPU from reset (fetch from PC 0).
// Image: MAGIC | count[7:0] | count[15:8] | count*4 payload bytes | xor csum
// (checksum is the xor of the payload bytes only).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_ready   byte stream in, transfer = valid & ready
//   reload         one-cycle pulse: abort, hold CPU, return to IDLE
//   imem_we/imem_addr/imem_wdata  one-cycle word write into instruction memory
//   cpu_rst_n      0 holds the CPU in reset, 1 lets it run
//   load_done      image accepted, CPU running
//   load_err       last image rejected (length or checksum)
// -----------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter int         DEPTH  = 1024,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err
);

    // One extra bit so a DEPTH-word image counts to DEPTH without wrapping.
    localparam int IDX_W = ADDR_W + 1;

    loader_state_t      state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;

    logic               rx_fire;
    logic               rx_take;
    logic [COUNT_W-1:0] len_full;
    logic               packer_clear;
    logic               packer_valid;
    logic               packer_last;
    logic               packer_word_valid;
    logic [31:0]        packer_word;

    // The loader only stops accepting bytes once the CPU runs.
    assign rx_ready = (state_q != RUN);
    assign rx_fire  = rx_valid && rx_ready;
    // A byte arriving together with reload is dropped.
    assign rx_take  = rx_fire && !reload;
    assign len_full = {rx_data, count_q[7:0]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_idx_d   = word_idx_q;
        csum_d       = csum_q;
        addr_d       = addr_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        packer_clear = 1'b0;
        packer_valid = 1'b0;

        if (reload) begin
            state_d      = IDLE;
            cpu_rst_n_d  = 1'b0;
            load_done_d  = 1'b0;
            packer_clear = 1'b1;
        end else if (rx_take) begin
            unique case (state_q)
                IDLE, ERR: begin
                    if (rx_data == MAGIC) begin
                        state_d      = LEN_LO;
                        count_d      = '0;
                        word_idx_d   = '0;
                        csum_d       = 8'h00;
                        load_err_d   = 1'b0;
                        packer_clear = 1'b1;
                    end
                end
                LEN_LO: begin
                    count_d[7:0] = rx_data;
                    state_d      = LEN_HI;
                end
                LEN_HI: begin
                    count_d[15:8] = rx_data;
                    if (len_full == '0) begin
                        state_d = CSUM;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d       = csum_q ^ rx_data;
                    packer_valid = 1'b1;
                    if (packer_last) begin
                        // Address registered alongside the packer's word so
                        // both appear in the cycle imem_we is high.
                        addr_d     = word_idx_q[ADDR_W-1:0];
                        word_idx_d = word_idx_q + IDX_W'(1);
                        if (COUNT_W'(word_idx_q) == (count_q - COUNT_W'(1))) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_data == csum_q) begin
                        state_d     = RUN;
                        cpu_rst_n_d = 1'b1;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end
                end
                default: begin
                    // RUN never accepts a byte (rx_ready low).
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            csum_q      <= 8'h00;
            addr_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_valid (packer_valid),
        .byte_data  (rx_data),
        .last_lane  (packer_last),
        .word_valid (packer_word_valid),
        .word_data  (packer_word)
    );

    assign imem_we    = packer_word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = packer_word;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader: directed images plus randomized
// images, compared against an image-level reference model (expected write
// list and final status computed from the image format rules).
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              load_done;
    logic              load_err;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] addr_log[$];
    logic [31:0]       data_log[$];
    logic [31:0]       img_words[$];
    logic [7:0]        junk_q[$];
    logic              model_err = 1'b0;

    imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Record every instruction-memory write.
    always @(negedge clk) begin
        if (imem_we) begin
            addr_log.push_back(imem_addr);
            data_log.push_back(imem_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  64'(rx_ready),   64'd1);
        check({tag, "_imem_we"},   64'(imem_we),    64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr),  64'd0);
        check({tag, "_imem_wdata"},64'(imem_wdata), 64'd0);
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n),  64'd0);
        check({tag, "_load_done"}, 64'(load_done),  64'd0);
        check({tag, "_load_err"},  64'(load_err),   64'd0);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("reload_load_done", 64'(load_done), 64'd0);
        check("reload_rx_ready",  64'(rx_ready),  64'd1);
        check("reload_load_err",  64'(load_err),  64'(model_err));
    endtask

    // Sends junk_q, then one image of `count` words from img_words, then the
    // checksum (flipped when corrupt). The model: words go to addresses
    // 0..count-1 unless count exceeds DEPTH; the CPU runs only on a good checksum.
    task automatic run_image(input int count, input bit corrupt, input bit gaps);
        logic [7:0]  csum;
        logic [7:0]  b;
        logic [15:0] cnt16;
        addr_log.delete();
        data_log.delete();
        foreach (junk_q[i]) begin
            send_byte(junk_q[i]);
            gap(gaps);
        end
        junk_q.delete();
        cnt16 = 16'(count);
        send_byte(8'hA5);
        gap(gaps);
        send_byte(cnt16[7:0]);
        gap(gaps);
        send_byte(cnt16[15:8]);
        if (count > DEPTH) begin
            model_err = 1'b1;
            check("oversize_load_err",  64'(load_err),  64'd1);
            check("oversize_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
            check("oversize_rx_ready",  64'(rx_ready),  64'd1);
            repeat (3) @(negedge clk);
            check("oversize_writes", 64'(addr_log.size()), 64'd0);
            return;
        end
        gap(gaps);
        csum = 8'h00;
        for (int w = 0; w < count; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = img_words[w][8*k +: 8];
                csum = csum ^ b;
                send_byte(b);
                gap(gaps);
            end
        end
        send_byte(corrupt ? (csum ^ 8'h01) : csum);
        model_err = corrupt;
        check("status_cpu_rst_n", 64'(cpu_rst_n), 64'(!corrupt));
        check("status_load_done", 64'(load_done), 64'(!corrupt));
        check("status_load_err",  64'(load_err),  64'(corrupt));
        check("status_rx_ready",  64'(rx_ready),  64'(corrupt));
        repeat (2) @(negedge clk);
        check("write_count", 64'(addr_log.size()), 64'(count));
        for (int w = 0; w < count && w < addr_log.size(); w++) begin
            check("write_addr", 64'(addr_log[w]), 64'(w));
            check("write_data", 64'(data_log[w]), 64'(img_words[w]));
        end
        $display("image count=%0d corrupt=%0d writes=%0d", count, corrupt, addr_log.size());
    endtask

    initial begin
        // ---- power-on reset ----
        #1 rst = 1'b0;
        #2;
        check_reset_values("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---- good image (checksum = 13^93^10 = 0x90) ----
        img_words.delete();
        img_words.push_back(32'h0000_0013);
        img_words.push_back(32'h0010_0093);
        run_image(2, 1'b0, 1'b0);
        check("good_rx_blocked", 64'(rx_ready), 64'd0);

        // ---- bad checksum, then good resend ----
        do_reload();
        run_image(2, 1'b1, 1'b0);
        run_image(2, 1'b0, 1'b1);

        // ---- oversize, then exactly DEPTH words ----
        do_reload();
        run_image(DEPTH + 1, 1'b0, 1'b0);
        img_words.delete();
        for (int i = 0; i < DEPTH; i++) img_words.push_back($urandom());
        run_image(DEPTH, 1'b0, 1'b0);
        if (addr_log.size() > 0)
            check("depth_last_addr", 64'(addr_log[addr_log.size()-1]), 64'(DEPTH - 1));

        // ---- noise then empty image ----
        do_reload();
        junk_q.push_back(8'h00);
        junk_q.push_back(8'hFF);
        junk_q.push_back(8'h12);
        run_image(0, 1'b0, 1'b0);

        // ---- reload mid-word with a byte in the same cycle ----
        do_reload();
        addr_log.delete();
        data_log.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        reload   = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_writes",    64'(addr_log.size()), 64'd0);
        check("abort_cpu_rst_n", 64'(cpu_rst_n),       64'd0);
        img_words.delete();
        img_words.push_back($urandom());
        run_image(1, 1'b0, 1'b0);

        // ---- asynchronous reset in the middle of DATA ----
        do_reload();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(1, 255)));
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        addr_log.delete();
        data_log.delete();
        for (int i = 0; i < 6; i++) send_byte(8'h5A);
        repeat (3) @(negedge clk);
        check("midreset_writes",   64'(addr_log.size()), 64'd0);
        check("midreset_cpu_rst_n",64'(cpu_rst_n),       64'd0);
        model_err = 1'b0;

        // ---- randomized images ----
        for (int n = 0; n < 10; n++) begin
            int cnt;
            bit bad_csum;
            if (cpu_rst_n) do_reload();
            cnt = $urandom_range(0, 6);
            bad_csum = ($urandom_range(0, 3) == 0);
            img_words.delete();
            for (int i = 0; i < cnt; i++) img_words.push_back($urandom());
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                logic [7:0] j;
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                junk_q.push_back(j);
            end
            run_image(cnt, bad_csum, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
